// File: rtl/acc_pkg.sv
// Shared types for the accumulator operand feeder slice.
package acc_pkg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    typedef logic signed [WIDTH-1:0] operand_t;

    typedef enum logic {
        RUN = 1'b0,
        CLR = 1'b1
    } feeder_state_e;

endpackage

// File: rtl/acc_operand_feeder_if.sv
// Producer/controller-facing bus of the operand feeder.
interface acc_operand_feeder_if #(
    parameter int unsigned WIDTH = acc_pkg::WIDTH,
    parameter int unsigned DEPTH = acc_pkg::DEPTH
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic                    i_valid;
    logic signed [WIDTH-1:0] i_data;
    logic                    o_ready;
    logic                    i_hold;
    logic                    i_clr;
    logic signed [WIDTH-1:0] o_a;
    logic                    o_a_vld;
    logic                    o_acc_clr;
    logic [LW-1:0]           o_level;

    modport master (
        output i_valid, i_data, i_hold, i_clr,
        input  o_ready, o_a, o_a_vld, o_acc_clr, o_level
    );

    modport slave (
        input  i_valid, i_data, i_hold, i_clr,
        output o_ready, o_a, o_a_vld, o_acc_clr, o_level
    );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO: storage, wrapping pointers and occupancy.
// rdata is the entry at the read pointer; the caller registers it on pop.
module sync_fifo #(
    parameter int unsigned WIDTH = acc_pkg::WIDTH,
    parameter int unsigned DEPTH = acc_pkg::DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);
    import acc_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push && !rst && !clr) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/acc_operand_feeder.sv
// Buffers producer operands and feeds one per cycle to the accumulator,
// with a flush that empties the FIFO and pulses the accumulator clear.
module acc_operand_feeder #(
    parameter int unsigned WIDTH = acc_pkg::WIDTH,
    parameter int unsigned DEPTH = acc_pkg::DEPTH
) (
    input  logic          i_clk,
    input  logic          i_rst,
    acc_operand_feeder_if.slave bus
);
    import acc_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);

    feeder_state_e    state;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] rdata;
    logic [AW:0]      level;
    logic [WIDTH-1:0] a_q;
    logic             a_vld_q;

    // Clear dominates both directions of traffic in the same cycle.
    assign push = bus.i_valid && !full && !bus.i_clr;
    assign pop  = !empty && !bus.i_hold && !bus.i_clr;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .clr   (bus.i_clr),
        .push  (push),
        .pop   (pop),
        .wdata (bus.i_data),
        .rdata (rdata),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= RUN;
            a_q     <= '0;
            a_vld_q <= 1'b0;
        end else begin
            case (state)
                RUN: if (bus.i_clr)  state <= CLR;
                CLR: if (!bus.i_clr) state <= RUN;
            endcase

            if (bus.i_clr) begin
                a_q     <= '0;
                a_vld_q <= 1'b0;
            end else if (pop) begin
                a_q     <= rdata;
                a_vld_q <= 1'b1;
            end else begin
                a_vld_q <= 1'b0;
            end
        end
    end

    assign bus.o_ready   = !full;
    assign bus.o_level   = level;
    assign bus.o_a       = a_q;
    assign bus.o_a_vld   = a_vld_q;
    assign bus.o_acc_clr = (state == CLR);

endmodule

// File: doc/acc_operand_feeder.md
Name: acc_operand_feeder

Overview:
- Upstream stage of accumulator_8bit: buffers signed 8-bit operands from a producer and presents exactly one operand per cycle on the accumulator's i_a input.
- Small synchronous FIFO, valid/ready on the write side, hold/stall input from the downstream controller.
- Registered operand-valid strobe and a one-cycle accumulator-clear pulse.
- Decouples bursty producers from the accumulator's one-add-per-clock datapath.

Parameters:
- WIDTH, 8, operand width in bits (two's complement).
- DEPTH, 4, FIFO entries; power of two, ≥2.
- AW, $clog2(DEPTH), pointer width (localparam, not overridable).

Ports:
- i_clk  in  1  clock, rising-edge.
- i_rst  in  1  synchronous active-high reset.
- i_valid  in  1  producer presents i_data this cycle.
- i_data  in  WIDTH  signed operand.
- o_ready  out  1  FIFO can accept; push occurs when i_valid && o_ready.
- i_hold  in  1  downstream stall; no pop while high.
- i_clr  in  1  flush request: empty FIFO and clear accumulator.
- o_a  out  WIDTH  operand to accumulator i_a (registered).
- o_a_vld  out  1  o_a is a new operand this cycle; accumulator adds it.
- o_acc_clr  out  1  one-cycle pulse; drives accumulator clear.
- o_level  out  AW+1  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset: synchronous active-high. Any cycle with i_rst=1 forces the following values at the next edge: pointers=0, o_level=0, o_a=0, o_a_vld=0, o_acc_clr=0. o_ready is 1 once i_rst is low. Reset mid-burst discards all buffered operands; there is no partial pop.
- o_ready = (o_level != DEPTH). It is combinational from registered state only and has no dependence on i_valid, i_hold or i_clr.
- Push: when i_valid && o_ready && !i_clr, write i_data at wr_ptr. wr_ptr wraps DEPTH-1 → 0.
- Pop: when o_level != 0 && !i_hold && !i_clr, the next edge sets o_a = mem[rd_ptr], o_a_vld = 1 and advances rd_ptr (wraps). Otherwise o_a_vld = 0 and o_a holds its last value.
- There is no write-through. Latency is 2 cycles from push edge to o_a_vld: push captured at edge N, pop at edge N+1.
- Simultaneous push and pop: both occur and o_level is unchanged. This is legal at any non-full level.
- Full: o_ready=0 and pushes are ignored. This holds even if a pop happens in the same cycle, so there is no full-bypass.
- Empty: no pop and o_a_vld=0. i_hold has no effect when empty.
- Clear, i_clr=1 at edge N:
  - Pointers and o_level go to 0; o_a goes to 0; o_a_vld goes to 0.
  - o_acc_clr=1 for the cycle after edge N only.
  - A push or pop in the same cycle is dropped; clear wins.
- i_clr held for k cycles gives o_acc_clr high for k cycles. i_rst has priority over i_clr.
- Data passes through unmodified. There is no sign-extension or saturation; overflow is the accumulator's concern.
- Control: two-state FSM.
  - RUN → CLR on i_clr.
  - CLR → RUN when i_clr=0.
  - o_acc_clr = (state==CLR). Reset state is RUN.

Decomposition:
- Package acc_pkg: WIDTH default, operand_t (logic signed [WIDTH-1:0]), feeder_state_e {RUN, CLR}.
- Natural sub-module: sync_fifo (storage, pointers, level, full/empty). acc_operand_feeder wraps it with the pop/clear FSM and output registers.

Test Plan:
- Reset then idle → o_ready=1, o_level=0, o_a_vld=0, o_acc_clr=0 for 5 cycles.
- Push 80, 80, 100, -50, 127 back-to-back with i_hold=0:
  - o_a_vld high for 5 consecutive cycles, starting 2 cycles after the first push.
  - o_a = 80, 80, 100, -50, 127 in order.
  - o_level never exceeds 1.
- i_hold=1, push 1, 2, 3, 4, 5:
  - o_ready drops after the 4th push and the 5th is rejected; o_level=4.
  - Release hold: o_a = 1, 2, 3, 4, then o_a_vld=0.
  - Check pointer wrap with a further 4 pushes.
- Fill 3 entries (10, 20, 30), then assert i_clr for 1 cycle with i_valid=1, i_data=99:
  - o_acc_clr pulses exactly 1 cycle; o_level=0; o_a=0.
  - 99 is not stored; no o_a_vld follows.
- At level 2, push and pop concurrently for 6 cycles → o_level stays 2; outputs in FIFO order.
- Assert i_rst for 1 cycle with level 3 mid-stream → all outputs at reset values next cycle; the next push of 7 appears as o_a=7 two cycles later.
